pipe_carry_skip_adder: RTL



---
 rtl/csa_pkg.sv | 15 +
 rtl/csa_block.sv | 35 +++
 rtl/pipe_carry_skip_adder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/csa_pkg.sv
// csa_pkg: shared defaults and helpers for the pipelined carry-skip adder.
package csa_pkg;

  localparam int CSA_WIDTH_DEF = 16;
  localparam int CSA_BLK_DEF   = 4;

  // Number of skip blocks (and pipeline stages); never less than one so that
  // array declarations stay legal even when the parameter check fires.
  function automatic int csa_nblk(input int width, input int blk);
    if (blk < 1) return 1;
    if ((width / blk) < 1) return 1;
    return width / blk;
  endfunction

endpackage

// File: rtl/csa_block.sv
// csa_block: one BLK-bit carry-skip block (ripple sum plus explicit skip mux).
module csa_block
  import csa_pkg::*;
#(
  parameter int BLK = CSA_BLK_DEF
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co
);

  logic [BLK-1:0] p;
  logic [BLK-1:0] g;
  logic [BLK:0]   rc;

  assign p = a ^ b;
  assign g = a & b;

  // Ripple carry chain through the block.
  always_comb begin
    rc    = '0;
    rc[0] = ci;
    for (int i = 0; i < BLK; i++) begin
      rc[i+1] = g[i] | (p[i] & rc[i]);
    end
  end

  assign s = p ^ rc[BLK-1:0];

  // Skip mux kept as a distinct mux: all-propagate passes the block carry-in.
  assign co = (&p) ? ci : rc[BLK];

endmodule

// File: rtl/pipe_carry_skip_adder.sv
// pipe_carry_skip_adder: WIDTH-bit adder resolving one BLK-bit carry-skip
// block per pipeline stage behind an operand register, valid/ready handshake
// with a global stall. Optional signed overflow output under CSA_OVF_EN.
module pipe_carry_skip_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH_DEF,
  parameter int BLK   = CSA_BLK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NBLK = csa_nblk(WIDTH, BLK);

  if (BLK < 1) begin : g_bad_blk
    $error("pipe_carry_skip_adder: BLK must be at least 1");
  end else if ((WIDTH % BLK) != 0) begin : g_bad_width
    $error("pipe_carry_skip_adder: WIDTH must be a multiple of BLK");
  end

`ifdef CSA_OVF_EN
  // Signed overflow: like-signed operands producing an opposite-signed sum.
  function automatic logic ovf_calc(input logic am, input logic bm, input logic sm);
    return (am == bm) & (sm != am);
  endfunction
`endif

  // Index k holds the operands/partial result entering block k.
  logic [NBLK-1:0]           vld_p;
  logic [NBLK-1:0]           cry_p;
  logic [WIDTH-1:0]          opa_p [NBLK];
  logic [WIDTH-1:0]          opb_p [NBLK];
  logic [WIDTH-1:0]          sum_p [NBLK];
  logic [NBLK-1:0][BLK-1:0]  blk_s;
  logic [NBLK-1:0]           blk_co;
  logic                      stall;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // ---- operand register: accept a new operation or a bubble ----
  // Valid for the operand register; frozen during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p[0] <= 1'b0;
    end else if (!stall) begin
      vld_p[0] <= in_valid;
    end
  end

  // Operand capture; cin seeds the running carry of block 0.
  always_ff @(posedge clk) begin
    if (!stall) begin
      opa_p[0] <= a;
      opb_p[0] <= b;
      cry_p[0] <= cin;
      sum_p[0] <= '0;
    end
  end

  for (genvar k = 0; k < NBLK; k++) begin : g_stage

    csa_block #(.BLK(BLK)) u_blk (
      .a  (opa_p[k][k*BLK +: BLK]),
      .b  (opb_p[k][k*BLK +: BLK]),
      .ci (cry_p[k]),
      .s  (blk_s[k]),
      .co (blk_co[k])
    );

    logic [WIDTH-1:0] snext;

    // Merge this block's sum bits into the partial result.
    always_comb begin
      snext                 = sum_p[k];
      snext[k*BLK +: BLK]   = blk_s[k];
    end

    if (k < NBLK - 1) begin : g_mid
      // ---- stage k -> stage k+1 boundary ----
      // Valid advances one stage per unstalled cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p[k+1] <= 1'b0;
        end else if (!stall) begin
          vld_p[k+1] <= vld_p[k];
        end
      end

      // Partial sum, remaining operand bits and carry advance with valid.
      always_ff @(posedge clk) begin
        if (!stall) begin
          sum_p[k+1] <= snext;
          opa_p[k+1] <= opa_p[k];
          opb_p[k+1] <= opb_p[k];
          cry_p[k+1] <= blk_co[k];
        end
      end
    end else begin : g_last
      // ---- final stage -> output register boundary ----
      // Output register; data only reloads on a valid entry so it holds
      // the last result across bubbles as well as stalls.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          sum       <= '0;
          cout      <= 1'b0;
        end else if (!stall) begin
          out_valid <= vld_p[k];
          if (vld_p[k]) begin
            sum  <= snext;
            cout <= blk_co[k];
          end
        end
      end

`ifdef CSA_OVF_EN
      // Overflow registered alongside sum from the carried operand MSBs.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf <= 1'b0;
        end else if (!stall && vld_p[k]) begin
          ovf <= ovf_calc(opa_p[k][WIDTH-1], opb_p[k][WIDTH-1], snext[WIDTH-1]);
        end
      end
`endif
    end
  end

endmodule
